mem_port_arbiter: RTL and testbench

Shares the single read/write port of the matrix scratch memory between three requesters.
- Requester 0: the SPI vector/matrix loader (writes).
- Requester 1: the array result writeback path (writes).
- Requester 2: the result readout path (reads toward SPI).

It replaces ad-hoc w_en/w_addr muxing with round-robin arbitration, burst locking and tagged read-return routing. It sits between the Controller-side requesters and the memory macro.

---
 rtl/mem_port_arbiter_pkg.sv | 9 +
 rtl/mem_port_arbiter_if.sv | 25 ++
 rtl/mem_port_arbiter_rr_pick.sv | 25 ++
 rtl/mem_port_arbiter.sv | 82 ++++++++
 tb/tb_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared defaults, requester indices and arbiter state type
package mem_port_arbiter_pkg;
    localparam int DEF_ADDR_SIZE = 10;
    localparam int DEF_WORD_SIZE = 16;
    localparam int REQ_SPI = 0;
    localparam int REQ_RESULT = 1;
    localparam int REQ_READOUT = 2;
    typedef enum logic {ARB, LOCKED} arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side request/response bundle of the memory port arbiter
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int WORD_SIZE = DEF_WORD_SIZE
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_we;
    logic [NUM_REQ-1:0] req_lock;
    logic [NUM_REQ*ADDR_SIZE-1:0] req_addr;
    logic [NUM_REQ*WORD_SIZE-1:0] req_wdata;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [WORD_SIZE-1:0] rsp_data;
    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata,
        input req_ready, rsp_valid, rsp_data
    );
    modport slave (
        input req_valid, req_we, req_lock, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// mem_port_arbiter_rr_pick: round-robin one-hot selector starting at a pointer
module mem_port_arbiter_rr_pick #(
    parameter int NUM_REQ = 3,
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input logic [NUM_REQ-1:0] req,
    input logic [IW-1:0] ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0] idx,
    output logic any
);
    // First set request at or after ptr, wrapping modulo NUM_REQ
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && req[(int'(ptr) + k) % NUM_REQ]) begin
                any = 1'b1;
                idx = IW'((int'(ptr) + k) % NUM_REQ);
                gnt[(int'(ptr) + k) % NUM_REQ] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin, burst-locking arbiter for the single scratch memory port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int NUM_REQ = 3,
    parameter int MEM_LATENCY = 1
) (
    input logic clk,
    input logic rst_n,
    mem_port_arbiter_if.slave bus,
    output logic mem_en,
    output logic mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input logic [WORD_SIZE-1:0] mem_rdata,
    output logic busy
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    arb_state_t state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] gidx;
    logic [IW-1:0] nxt;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt;
    logic any;
    logic [MEM_LATENCY:0] tag_v;
    logic [IW-1:0] tag_i [MEM_LATENCY+1];

    assign elig = state == LOCKED ? bus.req_valid & (NUM_REQ'(1) << owner) : bus.req_valid;
    assign nxt = int'(gidx) == NUM_REQ - 1 ? '0 : gidx + 1'b1;

    mem_port_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req(elig),
        .ptr(rr_ptr),
        .gnt(gnt),
        .idx(gidx),
        .any(any)
    );

    assign bus.req_ready = rst_n ? gnt : '0;
    assign bus.rsp_valid = tag_v[MEM_LATENCY] ? NUM_REQ'(1) << tag_i[MEM_LATENCY] : '0;
    assign bus.rsp_data = mem_rdata;
    assign busy = state == LOCKED || |tag_v;

    // Arbitration state, lock ownership and the registered memory command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
            rr_ptr <= '0;
            owner <= '0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= any;
            mem_we <= any & bus.req_we[gidx];
            if (any) begin
                mem_addr <= bus.req_addr[gidx*ADDR_SIZE +: ADDR_SIZE];
                mem_wdata <= bus.req_wdata[gidx*WORD_SIZE +: WORD_SIZE];
                rr_ptr <= nxt;
                owner <= gidx;
                state <= bus.req_lock[gidx] ? LOCKED : ARB;
            end
        end
    end

    // Read tags travel alongside the memory pipeline so each return finds its requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int k = 0; k <= MEM_LATENCY; k++) tag_i[k] <= '0;
        end else begin
            tag_v <= {tag_v[MEM_LATENCY-1:0], any & ~bus.req_we[gidx]};
            tag_i[0] <= gidx;
            for (int k = 1; k <= MEM_LATENCY; k++) tag_i[k] <= tag_i[k-1];
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus scoreboard bench for latency-1 and latency-3 arbiters
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;
    localparam int N = REQ_READOUT + 1;
    localparam int AW = DEF_ADDR_SIZE;
    localparam int DW = DEF_WORD_SIZE;

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] we;
        logic [N-1:0] lock;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [N-1:0] exp;
    } vec_t;
    typedef struct {
        int due;
        logic we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mexp_t;
    typedef struct {
        int due;
        int idx;
        logic [DW-1:0] data;
    } rexp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] v, we, lk;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic m1_en, m1_we, m3_en, m3_we, busy1, busy3;
    logic [AW-1:0] m1_addr, m3_addr;
    logic [DW-1:0] m1_wdata, m1_rdata, m3_wdata, m3_rdata;
    logic [DW-1:0] mem1 [1<<AW];
    logic [DW-1:0] mem3 [1<<AW];
    logic [DW-1:0] p3 [2];
    logic [DW-1:0] ref_mem [1<<AW];
    logic loaded = 1'b0;

    mexp_t mq[$];
    rexp_t q1[$];
    rexp_t q3[$];
    vec_t tbl[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    mem_port_arbiter_if #(.NUM_REQ(N), .ADDR_SIZE(AW), .WORD_SIZE(DW)) b1 ();
    mem_port_arbiter_if #(.NUM_REQ(N), .ADDR_SIZE(AW), .WORD_SIZE(DW)) b3 ();

    assign b1.req_valid = v;
    assign b1.req_we = we;
    assign b1.req_lock = lk;
    assign b1.req_addr = addr;
    assign b1.req_wdata = wdata;
    assign b3.req_valid = v;
    assign b3.req_we = we;
    assign b3.req_lock = lk;
    assign b3.req_addr = addr;
    assign b3.req_wdata = wdata;

    mem_port_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .NUM_REQ(N), .MEM_LATENCY(1)) d1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave),
        .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
        .mem_rdata(m1_rdata), .busy(busy1)
    );
    mem_port_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .NUM_REQ(N), .MEM_LATENCY(3)) d3 (
        .clk(clk), .rst_n(rst_n), .bus(b3.slave),
        .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
        .mem_rdata(m3_rdata), .busy(busy3)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        return a == 'h10 ? 16'hBEEF : a == 'h20 ? 16'hCAFE : a == 'h21 ? 16'hF00D : 16'h3000 | 16'(a);
    endfunction

    function automatic logic [DW-1:0] wd(input int i, input logic [AW-1:0] a);
        return {4'hC, 2'(i), a};
    endfunction

    // Memory models: latency 1 and latency 3, preloaded once
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < (1 << AW); i++) begin
                mem1[i] = init_val(i);
                mem3[i] = init_val(i);
            end
            loaded = 1'b1;
        end
        if (m1_en && m1_we) mem1[m1_addr] = m1_wdata;
        if (m1_en && !m1_we) m1_rdata <= mem1[m1_addr];
        if (m3_en && m3_we) mem3[m3_addr] = m3_wdata;
        p3[0] <= mem3[m3_addr];
        p3[1] <= p3[0];
        m3_rdata <= p3[1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] vv, input logic [N-1:0] ww, input logic [N-1:0] ll,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        v = vv;
        we = ww;
        lk = ll;
        addr = {a2, a1, a0};
        wdata = {wd(2, a2), wd(1, a1), wd(0, a0)};
    endtask

    task automatic check_outputs();
        mexp_t m;
        rexp_t r;
        logic [N-1:0] e1;
        logic [N-1:0] e3;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            m = mq.pop_front();
            chk("mem_en1", 32'(m1_en), 1);
            chk("mem_we1", 32'(m1_we), 32'(m.we));
            chk("mem_addr1", 32'(m1_addr), 32'(m.addr));
            chk("mem_wdata1", 32'(m1_wdata), 32'(m.wdata));
            chk("mem_en3", 32'(m3_en), 1);
            chk("mem_we3", 32'(m3_we), 32'(m.we));
            chk("mem_addr3", 32'(m3_addr), 32'(m.addr));
        end else begin
            chk("mem_idle1", 32'({m1_en, m1_we}), 0);
            chk("mem_idle3", 32'({m3_en, m3_we}), 0);
        end
        e1 = '0;
        e3 = '0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            r = q1.pop_front();
            e1[r.idx] = 1'b1;
            chk("rsp_data1", 32'(b1.rsp_data), 32'(r.data));
        end
        if (q3.size() > 0 && q3[0].due == cyc) begin
            r = q3.pop_front();
            e3[r.idx] = 1'b1;
            chk("rsp_data3", 32'(b3.rsp_data), 32'(r.data));
        end
        chk("rsp_valid1", 32'(b1.rsp_valid), 32'(e1));
        chk("rsp_valid3", 32'(b3.rsp_valid), 32'(e3));
    endtask

    task automatic step(input vec_t t);
        int g;
        logic [AW-1:0] a [N];
        @(negedge clk);
        check_outputs();
        a[0] = t.a0;
        a[1] = t.a1;
        a[2] = t.a2;
        drive(t.v, t.we, t.lock, t.a0, t.a1, t.a2);
        #1;
        chk("ready1", 32'(b1.req_ready), 32'(t.exp));
        chk("ready3", 32'(b3.req_ready), 32'(t.exp));
        g = -1;
        for (int i = 0; i < N; i++) if (t.exp[i]) g = i;
        if (g >= 0) begin
            mq.push_back('{cyc + 1, t.we[g], a[g], wd(g, a[g])});
            if (t.we[g]) ref_mem[a[g]] = wd(g, a[g]);
            else begin
                q1.push_back('{cyc + 2, g, ref_mem[a[g]]});
                q3.push_back('{cyc + 4, g, ref_mem[a[g]]});
            end
        end
        cyc++;
    endtask

    initial begin
        vec_t idle;
        idle = '{v: '0, we: '0, lock: '0, a0: '0, a1: '0, a2: '0, exp: '0};
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
        // round robin 0,1,2,0,1,2 with all three writing
        tbl.push_back('{3'b111, 3'b111, 3'b000, 10'h040, 10'h050, 10'h060, 3'b001});
        tbl.push_back('{3'b111, 3'b111, 3'b000, 10'h041, 10'h051, 10'h061, 3'b010});
        tbl.push_back('{3'b111, 3'b111, 3'b000, 10'h042, 10'h052, 10'h062, 3'b100});
        tbl.push_back('{3'b111, 3'b111, 3'b000, 10'h043, 10'h053, 10'h063, 3'b001});
        tbl.push_back('{3'b111, 3'b111, 3'b000, 10'h044, 10'h054, 10'h064, 3'b010});
        tbl.push_back('{3'b111, 3'b111, 3'b000, 10'h045, 10'h055, 10'h065, 3'b100});
        // requester 0 burst of four with an idle owner cycle in the middle
        tbl.push_back('{3'b111, 3'b111, 3'b001, 10'h000, 10'h070, 10'h080, 3'b001});
        tbl.push_back('{3'b111, 3'b111, 3'b001, 10'h001, 10'h070, 10'h080, 3'b001});
        tbl.push_back('{3'b110, 3'b111, 3'b000, 10'h001, 10'h070, 10'h080, 3'b000});
        tbl.push_back('{3'b111, 3'b111, 3'b001, 10'h002, 10'h070, 10'h080, 3'b001});
        tbl.push_back('{3'b111, 3'b111, 3'b000, 10'h003, 10'h070, 10'h080, 3'b001});
        tbl.push_back('{3'b110, 3'b111, 3'b000, 10'h000, 10'h071, 10'h080, 3'b010});
        // write then read same address by requester 2
        tbl.push_back('{3'b100, 3'b100, 3'b000, 10'h000, 10'h000, 10'h030, 3'b100});
        tbl.push_back('{3'b100, 3'b000, 3'b000, 10'h000, 10'h000, 10'h030, 3'b100});
        // single read of 0x10 by requester 2
        tbl.push_back('{3'b100, 3'b000, 3'b000, 10'h000, 10'h000, 10'h010, 3'b100});
        for (int i = 0; i < 4; i++) tbl.push_back(idle);
        // back-to-back reads by requesters 1 and 2
        tbl.push_back('{3'b110, 3'b000, 3'b000, 10'h000, 10'h020, 10'h021, 3'b010});
        tbl.push_back('{3'b100, 3'b000, 3'b000, 10'h000, 10'h000, 10'h021, 3'b100});
        for (int i = 0; i < 6; i++) tbl.push_back(idle);
        // pointer holds across idle cycles and wraps
        tbl.push_back('{3'b011, 3'b011, 3'b000, 10'h0A0, 10'h0A1, 10'h000, 3'b001});
        tbl.push_back('{3'b101, 3'b101, 3'b000, 10'h0A2, 10'h000, 10'h0A3, 3'b100});
        tbl.push_back('{3'b110, 3'b110, 3'b000, 10'h000, 10'h0A4, 10'h0A5, 3'b010});

        drive('1, '1, '0, 10'h001, 10'h002, 10'h003);
        repeat (3) @(negedge clk);
        chk("rst_ready1", 32'(b1.req_ready), 0);
        chk("rst_ready3", 32'(b3.req_ready), 0);
        chk("rst_mem_en", 32'({m1_en, m3_en}), 0);
        chk("rst_busy", 32'({busy1, busy3}), 0);
        chk("rst_rsp", 32'({b1.rsp_valid, b3.rsp_valid}), 0);
        drive('0, '0, '0, 10'h000, 10'h000, 10'h000);
        rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i]);

        // locked read by requester 0, then reset before its data returns
        step('{3'b001, 3'b000, 3'b001, 10'h010, 10'h000, 10'h000, 3'b001});
        @(negedge clk);
        check_outputs();
        chk("lock_busy1", 32'(busy1), 1);
        chk("lock_busy3", 32'(busy3), 1);
        rst_n = 1'b0;
        q1.delete();
        q3.delete();
        mq.delete();
        #1;
        chk("rst2_ready1", 32'(b1.req_ready), 0);
        chk("rst2_busy", 32'({busy1, busy3}), 0);
        cyc++;
        repeat (2) begin
            @(negedge clk);
            check_outputs();
            cyc++;
        end
        drive('0, '0, '0, 10'h000, 10'h000, 10'h000);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(idle);
        chk("post_busy1", 32'(busy1), 0);
        chk("post_busy3", 32'(busy3), 0);
        chk("post_state1", 32'(d1.state), 32'(ARB));
        step('{3'b010, 3'b010, 3'b000, 10'h000, 10'h0B0, 10'h000, 3'b010});
        step(idle);
        step(idle);
        chk("drain", 32'(mq.size() + q1.size() + q3.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
